// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read; pushes while full and
// pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter, LSB first, runtime baud divisor.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_buffered #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_tx_pkg::*;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, timer_q, timer_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic               par_q, par_d, tx_q, tx_d;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0]  fifo_dout;
  logic               bit_end, last_data, last_stop;

  uart_tx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready   = !fifo_full;
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;
  assign bit_end   = (timer_q == div_q);
  assign last_data = (bit_q == CNT_W'(DATA_W - 1));
  assign last_stop = (bit_q == CNT_W'(STOP_BITS - 1));

  // Next-state logic; a pop loads the word and freezes the divisor for the frame.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    div_d    = div_q;
    par_d    = par_q;
    fifo_pop = 1'b0;
    timer_d  = (state_q == IDLE || bit_end) ? '0 : timer_q + DIV_W'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + CNT_W'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      sh_d  = fifo_dout;
      div_d = baud_div;
      par_d = (^fifo_dout) ^ (PARITY_ODD != 0);
    end
  end

  // Line level is decoded from the next state so tx leaves a flop.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_d = ~IDLE_LEVEL;
      DATA:    tx_d = sh_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed steps feed a scoreboard of
// expected frames that a line monitor decodes and compares clock by clock.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P_BITS = 1;
`else
  localparam int P_BITS = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + P_BITS + STOP_BITS;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                div;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [DIV_W-1:0]            baud_div = 16'd3;
  logic                        s_valid = 1'b0;
  logic [DATA_W-1:0]           s_data = '0;
  logic                        s_ready, tx, busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   last_run = 0;

  uart_tx_buffered #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Length of the most recent unbroken stretch of busy, sampled on the falling edge.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_run <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offers one word, waits for the handshake and records what the line must carry.
  task automatic applyStimulus(input logic [DATA_W-1:0] w, input int div);
    bit   done;
    exp_t e;
    done = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        e.data = w;
        e.div  = div;
        exp_q.push_back(e);
        acc_cyc.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle(input int max_cycles);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < max_cycles && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    @(negedge clk);
    if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Line monitor: every frame on tx is matched against the oldest expected word.
  initial begin
    exp_t        e;
    logic [15:0] bits;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
        for (int i = 0; i < 200 && tx === 1'b0; i++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      bits = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < DATA_W; i++) bits[1+i] = e.data[i];
      if (P_BITS == 1) bits[1+DATA_W] = (^e.data) ^ (PARITY_ODD != 0);
      aborted = 1'b0;
      for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
        for (int t = 0; t <= e.div && !aborted; t++) begin
          if (!(b == 0 && t == 0)) @(negedge clk);
          if (rst !== 1'b0) aborted = 1'b1;
          else checkOutput("frame_bit", {31'd0, tx}, {31'd0, bits[b]});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] burst_w [6];
    int low;
    burst_w = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3};

    // Reset values while reset is held, then a quiet line with no traffic.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, s_ready}, 32'd1);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    low = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checkOutput("idle_tx_low_count", low, 0);
    @(posedge clk);
    #1;

    // Single frame: start bit two cycles after the handshake, busy for the whole frame.
    baud_div = 16'd3;
    applyStimulus(8'hA5, 3);
    @(negedge clk);
    checkOutput("f1_pre_tx", {31'd0, tx}, 32'd1);
    checkOutput("f1_pre_busy", {31'd0, busy}, 32'd0);
    checkOutput("f1_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    checkOutput("f1_start_tx", {31'd0, tx}, 32'd0);
    checkOutput("f1_start_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    waitIdle(200);
    checkOutput("f1_len", last_run, FRAME_BITS * 4);

    // Burst of six: five accepted back to back, then back-pressure until the first pop.
    acc_cyc.delete();
    for (int i = 0; i < 5; i++) applyStimulus(burst_w[i], 3);
    s_valid = 1'b1;
    s_data  = burst_w[5];
    @(negedge clk);
    checkOutput("burst_full_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("burst_full_level", 32'(fifo_level), 32'(FIFO_DEPTH));
    @(posedge clk);
    #1;
    applyStimulus(burst_w[5], 3);
    for (int i = 1; i < 5; i++) checkOutput("burst_consec", acc_cyc[i] - acc_cyc[0], i);
    checkOutput("burst_w5_cycle", acc_cyc[5] - acc_cyc[0], 2 + FRAME_BITS * 4);
    waitIdle(2000);
    checkOutput("burst_run", last_run, 6 * FRAME_BITS * 4);

    // Divisor change in data bit 2 of the first frame only affects the next frame.
    baud_div = 16'd3;
    applyStimulus(8'h3C, 3);
    applyStimulus(8'hC3, 1);
    repeat (13) @(posedge clk);
    #1;
    baud_div = 16'd1;
    waitIdle(500);
    checkOutput("div_run", last_run, FRAME_BITS * 4 + FRAME_BITS * 2);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit is 1, odd is 0.
    baud_div = 16'd3;
    applyStimulus(8'h07, 3);
    repeat (38) @(posedge clk);
    @(negedge clk);
    checkOutput("par_bit", {31'd0, tx}, (PARITY_ODD != 0) ? 32'd0 : 32'd1);
    @(posedge clk);
    #1;
    waitIdle(200);
    checkOutput("par_len", last_run, 44);
`endif

    // Reset in data bit 4 with two words queued: line idles and nothing follows.
    baud_div = 16'd3;
    applyStimulus(8'h5A, 3);
    applyStimulus(8'h11, 3);
    applyStimulus(8'h22, 3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_level", 32'(fifo_level), 32'd2);
    checkOutput("mid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low++;
    end
    checkOutput("post_rst_quiet", low, 0);

    checkOutput("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
